// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS symbol constants, period codes and encode helpers
package tmds_pkg;

  // Control symbols indexed by {c1,c0}
  localparam logic [9:0] CTRL_CODE [4] = '{
    10'b1101010100,
    10'b0010101011,
    10'b0101010100,
    10'b1010101011
  };

  // Video leading guard band symbols, chosen by lane parity
  localparam logic [9:0] GB_EVEN = 10'b1011001100;
  localparam logic [9:0] GB_ODD  = 10'b0100110011;

  // Video preamble control values; lane 0 keeps its sync bits
  localparam logic [1:0] PRE_CTRL_LANE1 = 2'b01;
  localparam logic [1:0] PRE_CTRL_OTHER = 2'b00;

  // Period encoding seen on o_period
  localparam logic [1:0] P_CTRL = 2'd0;
  localparam logic [1:0] P_PRE  = 2'd1;
  localparam logic [1:0] P_GB   = 2'd2;
  localparam logic [1:0] P_VID  = 2'd3;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, d[i]};
    end
    return c;
  endfunction

  // Transition-minimised word; bit 8 is 1 for the XOR path, 0 for XNOR
  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [8:0] q;
    logic [3:0] n1;
    logic       use_xnor;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// rtl/tmds_channel_enc.sv - one TMDS lane: two-stage 8b/10b encoder with running disparity
module tmds_channel_enc
  import tmds_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_de,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  input  logic       i_gb_sel,
  input  logic [9:0] i_gb_code,
  output logic [9:0] o_tmds
);

  logic              de_q;
  logic [1:0]        ctrl_q;
  logic              gb_sel_q;
  logic [9:0]        gb_code_q;
  logic [8:0]        qm_q;

  logic signed [4:0] cnt_q;
  logic signed [4:0] cnt_d;
  logic [9:0]        sym_d;

  logic [3:0]        n1_qm;
  logic [3:0]        n0_qm;
  logic signed [5:0] bal;
  logic signed [5:0] cnt_ext;
  logic signed [5:0] cnt_nx;

  // Stage 1: build q_m and carry the side-band fields alongside it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      de_q      <= 1'b0;
      ctrl_q    <= 2'b00;
      gb_sel_q  <= 1'b0;
      gb_code_q <= 10'd0;
      qm_q      <= 9'd0;
    end else begin
      de_q      <= i_de;
      ctrl_q    <= i_ctrl;
      gb_sel_q  <= i_gb_sel;
      gb_code_q <= i_gb_code;
      qm_q      <= tmds_qm(i_data);
    end
  end

  // Stage 2 decision: DC balance against the running disparity; any non-video cycle clears it
  always_comb begin
    n1_qm   = popcount8(qm_q[7:0]);
    n0_qm   = 4'd8 - n1_qm;
    bal     = $signed({2'b00, n1_qm}) - $signed({2'b00, n0_qm});
    cnt_ext = {cnt_q[4], cnt_q};
    cnt_nx  = 6'sd0;
    sym_d   = CTRL_CODE[ctrl_q];
    if (gb_sel_q) begin
      sym_d = gb_code_q;
    end else if (de_q) begin
      if ((cnt_q == 5'sd0) || (n1_qm == n0_qm)) begin
        sym_d  = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_nx = qm_q[8] ? (cnt_ext + bal) : (cnt_ext - bal);
      end else if (((cnt_q > 5'sd0) && (n1_qm > n0_qm)) ||
                   ((cnt_q < 5'sd0) && (n0_qm > n1_qm))) begin
        sym_d  = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_nx = cnt_ext + (qm_q[8] ? 6'sd2 : 6'sd0) - bal;
      end else begin
        sym_d  = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_nx = cnt_ext - (qm_q[8] ? 6'sd0 : 6'sd2) + bal;
      end
    end
    cnt_d = cnt_nx[4:0];
  end

  // Stage 2 registers: output symbol and disparity counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tmds <= CTRL_CODE[0];
      cnt_q  <= 5'sd0;
    end else begin
      o_tmds <= sym_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/tmds_encoder_nch.sv
// rtl/tmds_encoder_nch.sv - multi-lane TMDS encoder with optional HDMI preamble/guard band insertion
module tmds_encoder_nch
  import tmds_pkg::*;
#(
  parameter int CHANNELS  = 3,
  parameter int HDMI_MODE = 0,
  parameter int LOOKAHEAD = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_de,
  input  logic [CHANNELS*8-1:0]  i_data,
  input  logic [CHANNELS*2-1:0]  i_ctrl,
  output logic [CHANNELS*10-1:0] o_tmds,
  output logic                   o_de,
  output logic [1:0]             o_period,
  output logic                   o_short_blank
);

  // Lookahead only exists in HDMI mode; DVI feeds the encoder directly
  localparam int LA = (HDMI_MODE != 0) ? LOOKAHEAD : 0;

  logic                  de_enc;
  logic [CHANNELS*8-1:0] data_enc;
  logic [CHANNELS*2-1:0] ctrl_enc;
  logic [1:0]            period_enc;
  logic                  short_enc;

  logic                  de_s1_q;
  logic [1:0]            period_s1_q;
  logic                  short_s1_q;

  if (LA > 0) begin : g_hdmi
    localparam int FW = $clog2(LA + 1);
    localparam int CW = $clog2(LA + 3);

    logic [LA-1:0]         de_sr_q;
    logic [CHANNELS*8-1:0] data_sr_q [LA];
    logic [CHANNELS*2-1:0] ctrl_sr_q [LA];
    logic [LA:0]           stream;
    logic                  gb_hit;
    logic                  pre_hit;
    logic [FW-1:0]         fill_q;
    logic                  filled;
    logic [CW-1:0]         low_cnt_q;
    logic                  seen_q;

    // Delay line; index j holds the input from j+1 cycles ago
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        de_sr_q <= '0;
        for (int i = 0; i < LA; i++) begin
          data_sr_q[i] <= '0;
          ctrl_sr_q[i] <= '0;
        end
      end else begin
        de_sr_q[0]   <= i_de;
        data_sr_q[0] <= i_data;
        ctrl_sr_q[0] <= i_ctrl;
        for (int i = 1; i < LA; i++) begin
          de_sr_q[i]   <= de_sr_q[i-1];
          data_sr_q[i] <= data_sr_q[i-1];
          ctrl_sr_q[i] <= ctrl_sr_q[i-1];
        end
      end
    end

    // stream[LA-k] is de(t+k) relative to the encoder input at stream[LA]
    assign stream   = {de_sr_q, i_de};
    assign de_enc   = stream[LA];
    assign data_enc = data_sr_q[LA-1];
    assign filled   = (fill_q == FW'(LA));

    // Classify the encoder-input cycle; the nearest upcoming pixel decides guard band vs preamble.
    // Until the delay line holds post-reset data its de-low slots are filler, not a real gap.
    always_comb begin
      gb_hit  = 1'b0;
      pre_hit = 1'b0;
      for (int k = 1; k <= LA; k++) begin
        if (k <= 2) gb_hit  = gb_hit  | stream[LA-k];
        else        pre_hit = pre_hit | stream[LA-k];
      end
      if (de_enc)                 period_enc = P_VID;
      else if (filled && gb_hit)  period_enc = P_GB;
      else if (filled && pre_hit) period_enc = P_PRE;
      else                        period_enc = P_CTRL;
    end

    // Preamble forces lanes 1.. to the video-preamble control pattern
    always_comb begin
      ctrl_enc = ctrl_sr_q[LA-1];
      if (period_enc == P_PRE) begin
        for (int n = 1; n < CHANNELS; n++) begin
          ctrl_enc[2*n +: 2] = (n == 1) ? PRE_CTRL_LANE1 : PRE_CTRL_OTHER;
        end
      end
    end

    // Fill tracking, de-low run length and first-video tracking for the short-gap flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        fill_q    <= '0;
        low_cnt_q <= '0;
        seen_q    <= 1'b0;
      end else begin
        if (!filled) fill_q <= fill_q + 1'b1;
        if (de_enc) begin
          low_cnt_q <= '0;
          seen_q    <= 1'b1;
        end else if (low_cnt_q != CW'(LA + 2)) begin
          low_cnt_q <= low_cnt_q + 1'b1;
        end
      end
    end

    assign short_enc = de_enc && seen_q && (low_cnt_q != '0) &&
                       (low_cnt_q <= CW'(LA + 1));
  end else begin : g_dvi
    assign de_enc     = i_de;
    assign data_enc   = i_data;
    assign ctrl_enc   = i_ctrl;
    assign period_enc = i_de ? P_VID : P_CTRL;
    assign short_enc  = 1'b0;
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
    tmds_channel_enc u_enc (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_de      (de_enc),
      .i_data    (data_enc[8*n +: 8]),
      .i_ctrl    (ctrl_enc[2*n +: 2]),
      .i_gb_sel  (period_enc == P_GB),
      .i_gb_code ((n % 2 == 0) ? GB_EVEN : GB_ODD),
      .o_tmds    (o_tmds[10*n +: 10])
    );
  end

  // Side-band outputs follow the same two stages as the lane encoders
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      de_s1_q       <= 1'b0;
      period_s1_q   <= P_CTRL;
      short_s1_q    <= 1'b0;
      o_de          <= 1'b0;
      o_period      <= P_CTRL;
      o_short_blank <= 1'b0;
    end else begin
      de_s1_q       <= de_enc;
      period_s1_q   <= period_enc;
      short_s1_q    <= short_enc;
      o_de          <= de_s1_q;
      o_period      <= period_s1_q;
      o_short_blank <= short_s1_q;
    end
  end

endmodule

// File: tb/tb_tmds_encoder_nch.sv
// tb/tb_tmds_encoder_nch.sv - directed self-checking bench for DVI and HDMI encoder instances
module tb_tmds_encoder_nch;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] GBE = 10'b1011001100;
  localparam logic [9:0] GBO = 10'b0100110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_rst_n, d_de;
  logic [23:0] d_data;
  logic [5:0]  d_ctrl;
  logic [29:0] d_tmds;
  logic        d_ode, d_sb;
  logic [1:0]  d_per;

  logic        h_rst_n, h_de;
  logic [31:0] h_data;
  logic [7:0]  h_ctrl;
  logic [39:0] h_tmds;
  logic        h_ode, h_sb;
  logic [1:0]  h_per;

  int vectors = 0;
  int miscompares = 0;

  logic [9:0] vid [5];
  logic [9:0] z_seq [3];
  logic [9:0] exp_l [4];
  logic [1:0] pe;

  tmds_encoder_nch #(.CHANNELS(3), .HDMI_MODE(0), .LOOKAHEAD(10)) u_dvi (
    .i_clk(clk), .i_rst_n(d_rst_n), .i_de(d_de), .i_data(d_data), .i_ctrl(d_ctrl),
    .o_tmds(d_tmds), .o_de(d_ode), .o_period(d_per), .o_short_blank(d_sb)
  );

  tmds_encoder_nch #(.CHANNELS(4), .HDMI_MODE(1), .LOOKAHEAD(10)) u_hdmi (
    .i_clk(clk), .i_rst_n(h_rst_n), .i_de(h_de), .i_data(h_data), .i_ctrl(h_ctrl),
    .o_tmds(h_tmds), .o_de(h_ode), .o_period(h_per), .o_short_blank(h_sb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // FF data from zero disparity: 0 -> -8 -> -2 -> 4 -> -4 -> 2
    vid[0] = 10'b1000000000; vid[1] = 10'b0011111111; vid[2] = 10'b0011111111;
    vid[3] = 10'b1000000000; vid[4] = 10'b0011111111;
    // 00 data from zero disparity: 0 -> -8 -> 2 -> -6
    z_seq[0] = 10'b0100000000; z_seq[1] = 10'b1111111111; z_seq[2] = 10'b0100000000;

    // Reset held with random inputs
    d_rst_n = 1'b0; h_rst_n = 1'b0;
    d_de = 1'b1; d_data = 24'h123456; d_ctrl = 6'h3F;
    h_de = 1'b1; h_data = 32'hDEADBEEF; h_ctrl = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      d_de = 1'($urandom()); d_data = 24'($urandom()); d_ctrl = 6'($urandom());
      h_de = 1'($urandom()); h_data = $urandom(); h_ctrl = 8'($urandom());
      chk("rst_dvi_tmds", 64'(d_tmds), 64'({3{C00}}));
      chk("rst_dvi_de", 64'(d_ode), 64'(0));
      chk("rst_dvi_period", 64'(d_per), 64'(0));
      chk("rst_dvi_short", 64'(d_sb), 64'(0));
      chk("rst_hdmi_tmds", 64'(h_tmds), 64'({4{C00}}));
      chk("rst_hdmi_de", 64'(h_ode), 64'(0));
      chk("rst_hdmi_period", 64'(h_per), 64'(0));
    end

    // Release; DVI control 11 on lane 0
    d_rst_n = 1'b1; h_rst_n = 1'b1;
    d_de = 1'b0; d_ctrl = 6'b00_00_11; d_data = 24'($urandom());
    h_de = 1'b0; h_ctrl = 8'b11_11_11_10; h_data = 32'hFFFF_FFFF;
    tick();
    chk("rel_dvi_hold1", 64'(d_tmds), 64'({3{C00}}));
    tick();
    chk("dvi_ctrl_lane0", 64'(d_tmds[9:0]), 64'(C11));
    chk("dvi_ctrl_lane1", 64'(d_tmds[19:10]), 64'(C00));
    chk("dvi_ctrl_lane2", 64'(d_tmds[29:20]), 64'(C00));
    chk("dvi_ctrl_period", 64'(d_per), 64'(0));

    // DVI video: lane0=00, lane1=FF, lane2=55
    d_de = 1'b1; d_data = {8'h55, 8'hFF, 8'h00};
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dvi_vid_lane0", 64'(d_tmds[9:0]), 64'(z_seq[i]));
      chk("dvi_vid_lane1", 64'(d_tmds[19:10]), 64'(vid[i]));
      chk("dvi_vid_lane2", 64'(d_tmds[29:20]), 64'(10'b0100110011));
      chk("dvi_vid_period", 64'(d_per), 64'(3));
      chk("dvi_vid_de", 64'(d_ode), 64'(1));
      chk("dvi_vid_short", 64'(d_sb), 64'(0));
    end
    tick();
    chk("dvi_vid_lane0_4", 64'(d_tmds[9:0]), 64'(10'b1111111111));
    d_de = 1'b0;
    tick();
    d_de = 1'b1;
    tick();
    chk("dvi_gap_lane0", 64'(d_tmds[9:0]), 64'(C11));
    chk("dvi_gap_period", 64'(d_per), 64'(0));
    tick();
    chk("dvi_clr_lane0", 64'(d_tmds[9:0]), 64'(z_seq[0]));
    chk("dvi_clr_lane1", 64'(d_tmds[19:10]), 64'(vid[0]));

    repeat (12) tick();

    // HDMI: de rises after a long blank, 5-pixel run, 5-cycle gap, then video again
    h_de = 1'b1;
    for (int t = 1; t <= 23; t++) begin
      tick();
      h_de = (t >= 5 && t <= 9) ? 1'b0 : 1'b1;
      if (t <= 1)       pe = 2'd0;
      else if (t <= 9)  pe = 2'd1;
      else if (t <= 11) pe = 2'd2;
      else if (t <= 16) pe = 2'd3;
      else if (t <= 19) pe = 2'd1;
      else if (t <= 21) pe = 2'd2;
      else              pe = 2'd3;
      chk("hdmi_period", 64'(h_per), 64'(pe));
      chk("hdmi_de", 64'(h_ode), 64'(pe == 2'd3));
      chk("hdmi_short", 64'(h_sb), 64'(t == 22));
      case (pe)
        2'd0: begin exp_l[0] = C10; exp_l[1] = C11; exp_l[2] = C11; exp_l[3] = C11; end
        2'd1: begin exp_l[0] = C10; exp_l[1] = C01; exp_l[2] = C00; exp_l[3] = C00; end
        2'd2: begin exp_l[0] = GBE; exp_l[1] = GBO; exp_l[2] = GBE; exp_l[3] = GBO; end
        default: begin
          for (int n = 0; n < 4; n++) exp_l[n] = (t >= 22) ? vid[t-22] : vid[t-12];
        end
      endcase
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("hdmi_t%0d_lane%0d", t, n), 64'(h_tmds[10*n +: 10]), 64'(exp_l[n]));
      end
    end

    // Asynchronous reset in the middle of video
    tick();
    #2 h_rst_n = 1'b0;
    #1;
    chk("async_rst_tmds", 64'(h_tmds), 64'({4{C00}}));
    chk("async_rst_de", 64'(h_ode), 64'(0));
    chk("async_rst_period", 64'(h_per), 64'(0));
    chk("async_rst_short", 64'(h_sb), 64'(0));
    tick();
    h_rst_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t < 12) begin
        chk("post_rst_tmds", 64'(h_tmds), 64'({4{C00}}));
        chk("post_rst_period", 64'(h_per), 64'(0));
      end else begin
        for (int n = 0; n < 4; n++) begin
          chk($sformatf("post_rst_vid_lane%0d", n), 64'(h_tmds[10*n +: 10]), 64'(vid[0]));
        end
        chk("post_rst_vid_period", 64'(h_per), 64'(3));
        chk("post_rst_vid_de", 64'(h_ode), 64'(1));
        chk("post_rst_vid_short", 64'(h_sb), 64'(0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
